// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-requester memory bus arbiter. Requester 0 (CPU) and requester 1
// (DMA/video) share a single byte-wide memory port. Every access runs through
// three phases:
//   IDLE   - arbitrate between the pending requests (round-robin on a tie),
//            latch the winner's address, write data and direction.
//   ACCESS - hold the read or write strobe for WAIT_STATES+1 cycles, driving
//            the memory bus from the latched values.
//   DONE   - pulse the winner's ack for one cycle; reads capture mem_rdata on
//            the edge that enters this phase.
// At least one IDLE cycle separates consecutive accesses, and a request held
// continuously is simply re-arbitrated in that cycle.
//
// Parameters
//   WAIT_STATES  extra strobe cycles beyond the first (0..15)
//
// Ports
//   clk                         sole clock, rising edge
//   reset                       asynchronous, active-high reset
//   req0/addr0/wdata0/we0       requester 0 request, address, write data, dir
//   req1/addr1/wdata1/we1       requester 1 request, address, write data, dir
//   gnt0/gnt1                   bus ownership, held from grant through ack
//   ack0/ack1                   one-cycle completion pulse
//   rdata                       data of the last completed read
//   mem_addr/mem_wdata          memory address and write data
//   mem_rdata                   memory read data
//   mem_r/mem_w                 memory read / write strobes
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic [7:0]  wdata0,
  input  logic        we0,

  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata1,
  input  logic        we1,

  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,

  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_r,
  output logic        mem_w
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       we_latched;
  logic       last_gnt;   // requester granted most recently (1 = requester 1)
  logic       pick1;      // arbitration result for this cycle

  // Round-robin choice: a lone requester wins outright; on a tie the
  // requester that was not granted last wins.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here a default first), otherwise synthesis infers a latch.
  always_comb begin
    pick1 = 1'b0;
    if (req1 && (!req0 || !last_gnt))
      pick1 = 1'b1;
  end

  // Single sequential process: state, counter, latched request and all
  // outputs are registered together so every output changes on the edge that
  // changes the state. Reset clears the strobes and grants asynchronously,
  // which abandons an access in flight without an ack.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      we_latched <= 1'b0;
      last_gnt   <= 1'b1;   // requester 0 wins the first tie
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= 8'h00;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 8'h00;
      mem_r      <= 1'b0;
      mem_w      <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the ACCESS->DONE edge raises one.
      ack0 <= 1'b0;
      ack1 <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            if (pick1) begin
              gnt1       <= 1'b1;
              mem_addr   <= addr1;
              mem_wdata  <= wdata1;
              we_latched <= we1;
              mem_r      <= ~we1;
              mem_w      <= we1;
            end else begin
              gnt0       <= 1'b1;
              mem_addr   <= addr0;
              mem_wdata  <= wdata0;
              we_latched <= we0;
              mem_r      <= ~we0;
              mem_w      <= we0;
            end
            // The pointer moves only when an access actually starts.
            last_gnt <= pick1;
            wait_cnt <= WAIT_LOAD;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          // The strobe was raised on entry, so it is high for the entry cycle
          // plus one cycle per counted wait state.
          if (wait_cnt == 4'd0) begin
            mem_r <= 1'b0;
            mem_w <= 1'b0;
            if (!we_latched)
              rdata <= mem_rdata;
            ack0  <= gnt0;
            ack1  <= gnt1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        DONE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          mem_r <= 1'b0;
          mem_w <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Four copies of bus_arbiter (WAIT_STATES = 1, 0, 3, 15) share one set of
// inputs. A transaction-timeline model predicts every output of every copy:
// a grant at edge N makes the strobe high after edges N..N+W, the ack high
// after edge N+W+1, and the next grant possible at edge N+W+3.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1, mem_rdata;

  logic [N-1:0] gnt0_v, gnt1_v, ack0_v, ack1_v, mem_r_v, mem_w_v;
  logic [15:0]  mem_addr_v  [N];
  logic [7:0]   mem_wdata_v [N];
  logic [7:0]   rdata_v     [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bus_arbiter #(
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .we0       (we0),
      .req1      (req1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .we1       (we1),
      .gnt0      (gnt0_v[g]),
      .gnt1      (gnt1_v[g]),
      .ack0      (ack0_v[g]),
      .ack1      (ack1_v[g]),
      .rdata     (rdata_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_rdata (mem_rdata),
      .mem_r     (mem_r_v[g]),
      .mem_w     (mem_w_v[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  int          ws        [N];
  int          edge_n;
  bit          act       [N];
  int          start_e   [N];
  int          next_free [N];
  bit          who       [N];
  bit          twe       [N];
  logic [15:0] taddr     [N];
  logic [7:0]  twd       [N];
  logic [7:0]  mrd       [N];
  bit          last      [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      act[i]       = 1'b0;
      next_free[i] = 0;
      who[i]       = 1'b0;
      twe[i]       = 1'b0;
      taddr[i]     = 16'h0000;
      twd[i]       = 8'h00;
      mrd[i]       = 8'h00;
      last[i]      = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit w;
    edge_n++;
    for (int i = 0; i < N; i++) begin
      if (act[i] && (edge_n - start_e[i] == ws[i] + 1) && !twe[i])
        mrd[i] = mem_rdata;
      if (edge_n >= next_free[i] && (req0 || req1)) begin
        w            = (req0 && req1) ? !last[i] : req1;
        who[i]       = w;
        twe[i]       = w ? we1 : we0;
        taddr[i]     = w ? addr1 : addr0;
        twd[i]       = w ? wdata1 : wdata0;
        start_e[i]   = edge_n;
        next_free[i] = edge_n + ws[i] + 3;
        act[i]       = 1'b1;
        last[i]      = w;
      end
    end
  endtask

  task automatic compare_all();
    int d;
    bit in_tx, strobe, ackp;
    logic [5:0] exp6, got6;
    for (int i = 0; i < N; i++) begin
      d      = edge_n - start_e[i];
      in_tx  = act[i] && (d <= ws[i] + 1);
      strobe = act[i] && (d <= ws[i]);
      ackp   = act[i] && (d == ws[i] + 1);
      exp6 = {in_tx && !who[i], in_tx && who[i], ackp && !who[i], ackp && who[i],
              strobe && !twe[i], strobe && twe[i]};
      got6 = {gnt0_v[i], gnt1_v[i], ack0_v[i], ack1_v[i], mem_r_v[i], mem_w_v[i]};
      check($sformatf("ctl[%0d] e%0d", i, edge_n), 32'(got6), 32'(exp6));
      check($sformatf("excl[%0d] e%0d", i, edge_n),
            32'((gnt0_v[i] & gnt1_v[i]) | (ack0_v[i] & ack1_v[i]) | (mem_r_v[i] & mem_w_v[i])), 32'd0);
      check($sformatf("addr[%0d] e%0d", i, edge_n), 32'(mem_addr_v[i]), 32'(taddr[i]));
      check($sformatf("wdata[%0d] e%0d", i, edge_n), 32'(mem_wdata_v[i]), 32'(twd[i]));
      check($sformatf("rdata[%0d] e%0d", i, edge_n), 32'(rdata_v[i]), 32'(mrd[i]));
    end
  endtask

  // ---------------- stimulus helpers ----------------
  bit   track;
  int   gq[$];
  logic pg0, pg1;

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (track) begin
      if (gnt0_v[0] && !pg0) gq.push_back(0);
      if (gnt1_v[0] && !pg1) gq.push_back(1);
    end
    pg0 = gnt0_v[0];
    pg1 = gnt1_v[0];
  endtask

  task automatic pulse_reset();
    // Called at a falling edge; release comes before the next rising edge.
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    pg0 = 1'b0;
    pg1 = 1'b0;
    #1;
    reset = 1'b0;
  endtask

  task automatic randomize_inputs();
    req0      = ($urandom_range(0, 3) != 0);
    req1      = ($urandom_range(0, 2) != 0);
    addr0     = 16'($urandom);
    addr1     = 16'($urandom);
    wdata0    = 8'($urandom);
    wdata1    = 8'($urandom);
    we0       = 1'($urandom);
    we1       = 1'($urandom);
    mem_rdata = 8'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ws[0] = 1; ws[1] = 0; ws[2] = 3; ws[3] = 15;
    edge_n = 0;
    track  = 1'b0;
    pg0    = 1'b0;
    pg1    = 1'b0;
    reset  = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0; mem_rdata = 8'h0;
    model_reset();

    // Reset state, sampled while reset is still high.
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Single read by requester 0; request dropped and address changed after
    // the grant edge, memory returns A5.
    req0 = 1'b1; addr0 = 16'h2000; we0 = 1'b0; wdata0 = 8'h11; mem_rdata = 8'hA5;
    step();
    req0 = 1'b0; addr0 = 16'hFFFF;
    repeat (20) step();
    check("read_a5_ws1", 32'(rdata_v[0]), 32'h0000_00A5);
    check("read_a5_ws15", 32'(rdata_v[3]), 32'h0000_00A5);

    // Single write by requester 1; rdata must keep A5.
    req1 = 1'b1; addr1 = 16'h1234; wdata1 = 8'h3C; we1 = 1'b1; mem_rdata = 8'h5A;
    step();
    req1 = 1'b0;
    repeat (20) step();
    check("write_keeps_rdata", 32'(rdata_v[1]), 32'h0000_00A5);
    check("write_wdata", 32'(mem_wdata_v[1]), 32'h0000_003C);

    // Both requests held from reset: grants must alternate 0,1,0,1,...
    pulse_reset();
    gq.delete();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b1;
    track = 1'b1;
    repeat (40) step();
    track = 1'b0;
    check("alt_count_ge6", 32'(gq.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      check($sformatf("alt_order[%0d]", k), 32'(gq[k]), 32'(k % 2));

    // Reset in the middle of a WAIT_STATES=3 read; then a fresh request.
    req0 = 1'b0; req1 = 1'b0;
    repeat (20) step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h4444;
    step();
    step();
    check("ws3_mid_access", 32'(mem_r_v[2]), 32'd1);
    pulse_reset();
    addr0 = 16'h5555; mem_rdata = 8'h77;
    step();
    req0 = 1'b0;
    repeat (20) step();
    check("after_reset_read", 32'(rdata_v[2]), 32'h0000_0077);

    // Randomized traffic.
    repeat (1500) begin
      randomize_inputs();
      step();
    end

    req0 = 1'b0; req1 = 1'b0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
